oneshot_monitor: RTL and testbench

ONESHOT_MONITOR -- requirements
Module: oneshot_monitor

---
 rtl/oneshot_mon_pkg.sv | 14 +
 rtl/oneshot_monitor_sync2.sv | 21 ++
 rtl/oneshot_monitor.sv | 118 +++++++++++
 tb/tb_oneshot_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oneshot_mon_pkg.sv
// Shared FSM encoding and default sizing for the one-shot pulse-width monitor.
package oneshot_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_MIN_W = 4;
    localparam int DEF_MAX_W = 1000;

endpackage

// File: rtl/oneshot_monitor_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/oneshot_monitor.sv
// Measures the high time of a retriggerable one-shot output in clk cycles,
// flagging pulses that are too short or that saturate at MAX_W.
module oneshot_monitor
    import oneshot_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int MIN_W = DEF_MIN_W,
    parameter int MAX_W = DEF_MAX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             en,
    output logic             sync_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] width,
    output logic             short_err,
    output logic             long_err,
    output logic [7:0]       pulse_cnt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_C - ONE_C) ? MAX_C : v + ONE_C;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             prev_p1;
    logic             armed;
    logic [1:0]       flush_cnt;
    logic             rise;
    logic             fall;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pulse_in),
        .q     (sync_q)
    );

    assign rise = sync_q & ~prev_p1;
    assign fall = ~sync_q & prev_p1;

    // Edge-detect stage; armed stays low after reset until a genuine low level
    // has been seen, so a pulse already high at reset release is never measured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p1   <= 1'b0;
            armed     <= 1'b0;
            flush_cnt <= 2'd0;
            state     <= ST_IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            width     <= '0;
            short_err <= 1'b0;
            long_err  <= 1'b0;
            pulse_cnt <= 8'd0;
        end else begin
            prev_p1 <= sync_q;
            done    <= 1'b0;

            if (flush_cnt != 2'd2) begin
                flush_cnt <= flush_cnt + 2'd1;
            end else if (!sync_q) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rise && armed && en) begin
                        counter <= ONE_C;
                        busy    <= 1'b1;
                        if (ONE_C >= MAX_C) begin
                            counter <= MAX_C;
                            state   <= ST_OVER;
                        end else begin
                            state   <= ST_HIGH;
                        end
                    end
                end

                ST_HIGH, ST_OVER: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                    end else if (fall) begin
                        done      <= 1'b1;
                        width     <= counter;
                        long_err  <= (state == ST_OVER);
                        short_err <= (state != ST_OVER) && (counter < MIN_C);
                        pulse_cnt <= pulse_cnt + 8'd1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        counter   <= '0;
                    end else if (state == ST_HIGH) begin
                        counter <= sat_inc(counter);
                        if (counter >= MAX_C - ONE_C) begin
                            state <= ST_OVER;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oneshot_monitor.sv
// Bench for oneshot_monitor: two instances (default MAX_W and MAX_W=20) driven
// by the same pulses, compared against a pulse-level behavioural model.
module tb_oneshot_monitor;

    localparam int MIN_W = 4;
    localparam int MAXA  = 1000;
    localparam int MAXB  = 20;

    typedef struct packed {
        logic [15:0] w;
        logic        s;
        logic        l;
    } meas_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pulse_in;
    logic        en;

    logic        a_sync_q, a_busy, a_done, a_short, a_long;
    logic [15:0] a_width;
    logic [7:0]  a_cnt;
    logic        b_sync_q, b_busy, b_done, b_short, b_long;
    logic [15:0] b_width;
    logic [7:0]  b_cnt;

    int    checks   = 0;
    int    failures = 0;
    int    exp_cnt  = 0;
    meas_t ea       = '0;
    meas_t eb       = '0;
    meas_t qa[$];
    meas_t qb[$];

    always #5 clk = ~clk;

    oneshot_monitor #(.CNT_W(16), .MIN_W(MIN_W), .MAX_W(MAXA)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .en        (en),
        .sync_q    (a_sync_q),
        .busy      (a_busy),
        .done      (a_done),
        .width     (a_width),
        .short_err (a_short),
        .long_err  (a_long),
        .pulse_cnt (a_cnt)
    );

    oneshot_monitor #(.CNT_W(16), .MIN_W(MIN_W), .MAX_W(MAXB)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .en        (en),
        .sync_q    (b_sync_q),
        .busy      (b_busy),
        .done      (b_done),
        .width     (b_width),
        .short_err (b_short),
        .long_err  (b_long),
        .pulse_cnt (b_cnt)
    );

    always @(negedge clk) begin
        if (a_done) qa.push_back({a_width, a_short, a_long});
        if (b_done) qb.push_back({b_width, b_short, b_long});
    end

    // Expected result of a pulse sampled high for n cycles.
    function automatic meas_t model(input int n, input int maxw);
        meas_t m;
        m.w = 16'((n >= maxw) ? maxw : n);
        m.l = (n >= maxw);
        m.s = (n < maxw) && (n < MIN_W);
        return m;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input int n, input int gap);
        pulse_in = 1'b1;
        cycles(n);
        pulse_in = 1'b0;
        cycles(gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pulse_in = 1'b0; en = 1'b0;
        cycles(3);
        checks++;
        if ({a_sync_q, a_busy, a_done, a_width, a_short, a_long, a_cnt} !== '0)
            $display("FAIL reset_a got %h want 0", {a_sync_q, a_busy, a_done, a_width, a_short, a_long, a_cnt});
        checks++;
        if ({b_sync_q, b_busy, b_done, b_width, b_short, b_long, b_cnt} !== '0)
            $display("FAIL reset_b got %h want 0", {b_sync_q, b_busy, b_done, b_width, b_short, b_long, b_cnt});
        if ({a_sync_q, a_busy, a_done, a_width, a_short, a_long, a_cnt} !== '0) failures++;
        if ({b_sync_q, b_busy, b_done, b_width, b_short, b_long, b_cnt} !== '0) failures++;
        rst_n = 1'b1; en = 1'b1;
        cycles(4);
    endtask

    task automatic test_basic;
        qa.delete(); qb.delete();
        pulse_in = 1'b1;
        cycles(1);
        checks++;
        if (a_sync_q !== 1'b0) begin failures++; $display("FAIL sync_lat1 got %b want 0", a_sync_q); end
        cycles(1);
        checks++;
        if (a_sync_q !== 1'b1) begin failures++; $display("FAIL sync_lat2 got %b want 1", a_sync_q); end
        cycles(8);
        pulse_in = 1'b0;
        cycles(8);
        exp_cnt++; ea = model(10, MAXA); eb = model(10, MAXB);
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL basic_dones got %0d want 1", qa.size()); end
        else if (qa[0] !== ea) begin failures++; $display("FAIL basic_a got %h want %h", qa[0], ea); end
        checks++;
        if (qb.size() != 1) begin failures++; $display("FAIL basic_dones_b got %0d want 1", qb.size()); end
        else if (qb[0] !== eb) begin failures++; $display("FAIL basic_b got %h want %h", qb[0], eb); end
        checks++;
        if ({a_width, a_short, a_long} !== ea) begin failures++; $display("FAIL basic_held got %h want %h", {a_width, a_short, a_long}, ea); end
        checks++;
        if (a_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL basic_cnt got %0d want %0d", a_cnt, exp_cnt); end
    endtask

    task automatic test_short;
        qa.delete(); qb.delete();
        drive_pulse(2, 8);
        exp_cnt++; ea = model(2, MAXA); eb = model(2, MAXB);
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL short_dones got %0d want 1", qa.size()); end
        else if (qa[0] !== ea) begin failures++; $display("FAIL short_a got %h want %h", qa[0], ea); end
        checks++;
        if (b_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL short_cnt got %0d want %0d", b_cnt, exp_cnt); end
    endtask

    task automatic test_long;
        qa.delete(); qb.delete();
        pulse_in = 1'b1;
        cycles(30);
        checks++;
        if ({a_busy, b_busy} !== 2'b11) begin failures++; $display("FAIL long_busy got %b want 11", {a_busy, b_busy}); end
        cycles(20);
        pulse_in = 1'b0;
        cycles(8);
        exp_cnt++; ea = model(50, MAXA); eb = model(50, MAXB);
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL long_dones got %0d want 1", qa.size()); end
        else if (qa[0] !== ea) begin failures++; $display("FAIL long_a got %h want %h", qa[0], ea); end
        checks++;
        if (qb.size() != 1) begin failures++; $display("FAIL long_dones_b got %0d want 1", qb.size()); end
        else if (qb[0] !== eb) begin failures++; $display("FAIL long_b got %h want %h", qb[0], eb); end
        checks++;
        if ({a_busy, b_busy} !== 2'b00) begin failures++; $display("FAIL long_idle got %b want 00", {a_busy, b_busy}); end
    endtask

    // Retriggerable one-shot: each trigger restarts a 10-cycle high window.
    task automatic test_retrigger;
        int end_t;
        int hi;
        end_t = 0; hi = 0;
        qa.delete(); qb.delete();
        for (int t = 0; t < 35; t++) begin
            if (t == 0 || t == 8 || t == 15) end_t = t + 10;
            pulse_in = (t < end_t);
            if (t < end_t) hi++;
            cycles(1);
        end
        pulse_in = 1'b0;
        cycles(8);
        exp_cnt++; ea = model(hi, MAXA); eb = model(hi, MAXB);
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL retrig_dones got %0d want 1", qa.size()); end
        else if (qa[0] !== ea) begin failures++; $display("FAIL retrig_a got %h want %h", qa[0], ea); end
        checks++;
        if (qb.size() != 1) begin failures++; $display("FAIL retrig_dones_b got %0d want 1", qb.size()); end
        else if (qb[0] !== eb) begin failures++; $display("FAIL retrig_b got %h want %h", qb[0], eb); end
        checks++;
        if (a_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL retrig_cnt got %0d want %0d", a_cnt, exp_cnt); end
    endtask

    task automatic test_abort;
        qa.delete(); qb.delete();
        pulse_in = 1'b1; cycles(5);
        en = 1'b0; cycles(5);
        pulse_in = 1'b0; cycles(3);
        en = 1'b1; cycles(6);
        en = 1'b0; pulse_in = 1'b1; cycles(4);
        en = 1'b1; cycles(6);
        pulse_in = 1'b0; cycles(8);
        pulse_in = 1'b1; cycles(10);
        pulse_in = 1'b0; cycles(2);
        en = 1'b0; cycles(1);
        en = 1'b1; cycles(6);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin failures++; $display("FAIL abort_dones got %0d/%0d want 0", qa.size(), qb.size()); end
        checks++;
        if ({a_width, a_short, a_long} !== ea) begin failures++; $display("FAIL abort_held_a got %h want %h", {a_width, a_short, a_long}, ea); end
        checks++;
        if ({b_width, b_short, b_long} !== eb) begin failures++; $display("FAIL abort_held_b got %h want %h", {b_width, b_short, b_long}, eb); end
        checks++;
        if (a_cnt !== 8'(exp_cnt) || a_busy !== 1'b0) begin failures++; $display("FAIL abort_cnt got %0d busy %b want %0d busy 0", a_cnt, a_busy, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        qa.delete(); qb.delete();
        pulse_in = 1'b1; cycles(5);
        rst_n = 1'b0; #1;
        checks++;
        if ({a_sync_q, a_busy, a_done, a_width, a_short, a_long, a_cnt, b_width, b_cnt} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got %h want 0", {a_sync_q, a_busy, a_done, a_width, a_short, a_long, a_cnt, b_width, b_cnt});
        end
        #2 rst_n = 1'b1;
        exp_cnt = 0; ea = '0; eb = '0;
        cycles(10);
        pulse_in = 1'b0; cycles(8);
        checks++;
        if (qa.size() != 0 || a_cnt !== 8'd0 || a_width !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_ignored got dones %0d cnt %0d width %0d want 0 0 0", qa.size(), a_cnt, a_width);
        end
        drive_pulse(6, 8);
        exp_cnt++; ea = model(6, MAXA); eb = model(6, MAXB);
        checks++;
        if (qa.size() != 1) begin failures++; $display("FAIL rstmid_resume got %0d dones want 1", qa.size()); end
        else if (qa[0] !== ea || a_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL rstmid_resume got %h cnt %0d want %h cnt %0d", qa[0], a_cnt, ea, exp_cnt); end
    endtask

    task automatic test_random;
        meas_t xa[$];
        meas_t xb[$];
        int n;
        int gap;
        qa.delete(); qb.delete();
        for (int i = 0; i < 40; i++) begin
            n   = $urandom_range(1, 45);
            gap = $urandom_range(1, 4);
            xa.push_back(model(n, MAXA));
            xb.push_back(model(n, MAXB));
            drive_pulse(n, gap);
        end
        cycles(8);
        exp_cnt += 40;
        checks++;
        if (qa.size() != xa.size() || qb.size() != xb.size()) begin
            failures++;
            $display("FAIL rand_dones got %0d/%0d want %0d", qa.size(), qb.size(), xa.size());
        end else begin
            for (int i = 0; i < xa.size(); i++) begin
                checks++;
                if (qa[i] !== xa[i] || qb[i] !== xb[i]) begin
                    failures++;
                    $display("FAIL rand_pulse%0d got %h/%h want %h/%h", i, qa[i], qb[i], xa[i], xb[i]);
                end
            end
        end
        checks++;
        if (a_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL rand_cnt got %0d want %0d", a_cnt, exp_cnt & 255); end
    endtask

    task automatic test_back_to_back;
        int bad;
        bad = 0;
        rst_n = 1'b0; cycles(2);
        rst_n = 1'b1; cycles(4);
        qa.delete(); qb.delete();
        for (int i = 0; i < 256; i++) drive_pulse(5, 1);
        cycles(8);
        foreach (qa[i]) if (qa[i] !== model(5, MAXA)) bad++;
        checks++;
        if (qa.size() != 256 || bad != 0) begin failures++; $display("FAIL b2b_dones got %0d (bad %0d) want 256 (bad 0)", qa.size(), bad); end
        checks++;
        if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin failures++; $display("FAIL b2b_wrap got %0d/%0d want 0", a_cnt, b_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_long();
        test_retrigger();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
